alu_arbiter: RTL

Two-port arbiter and sequencer that shares the single 8-bit ALU datapath (add, shift right, shift left, XOR-reduce-into-bit, equality flag) between two requesters, e.g. the main issue path and a secondary address/branch unit. It accepts one operation at a time via a valid/ready handshake, registers operands into the ALU, captures the result and equality flag, and returns them to the granting requester with a held response handshake. It sits between the requesters and the ALU instance, driving every ALU input.

---
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signal bundle for alu_arbiter.
// master = requesters plus ALU (environment side), slave = the arbiter.
interface alu_arbiter_if #(
    parameter int W   = 8,
    parameter int OPS = 2
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [OPS-1:0] req0_op;
    logic [OPS-1:0] req1_op;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req0_b;
    logic [W-1:0]   req1_b;
    logic [W-1:0]   req0_c;
    logic [W-1:0]   req1_c;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [W-1:0]   resp_data;
    logic           resp_eq;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_c;
    logic [OPS-1:0] alu_op;
    logic [W-1:0]   alu_out;
    logic           alu_is_equal;

    modport master (
        output req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
               req0_c, req1_c, resp_ready, alu_out, alu_is_equal,
        input  req_ready, resp_valid, resp_data, resp_eq,
               alu_a, alu_b, alu_c, alu_op
    );

    modport slave (
        input  req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
               req0_c, req1_c, resp_ready, alu_out, alu_is_equal,
        output req_ready, resp_valid, resp_data, resp_eq,
               alu_a, alu_b, alu_c, alu_op
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for one shared ALU; ALU_ARB_RR_EN selects round-robin, else fixed priority to requester 0.
// Latency: accept at edge N, response valid in cycle N+2; at most one operation in flight (3-cycle minimum occupancy).
// Backpressure: req_ready only in IDLE; response held stable until resp_ready of the owning requester.
module alu_arbiter #(
    parameter int W   = 8,
    parameter int OPS = 2
) (
    input  logic    clk,
    input  logic    reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           owner;
    logic           rr;
    logic           gnt;
    logic           any_req;
    logic           resp_done;
    logic [OPS-1:0] op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   c_q;
    logic [W-1:0]   data_q;
    logic           eq_q;

    assign any_req   = |bus.req_valid;
    assign resp_done = (state == RESP) && bus.resp_ready[owner];

    // A lone requester always wins; rr only breaks a tie.
    assign gnt = bus.req_valid[0] ? (bus.req_valid[1] & rr) : bus.req_valid[1];

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= 1'b0;
        end else if (resp_done) begin
            rr <= ~owner;
        end
    end
`else
    assign rr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 2'b00;
        bus.resp_valid = 2'b00;
        if (state == IDLE && any_req) begin
            bus.req_ready = {gnt, ~gnt};
        end
        if (state == RESP) begin
            bus.resp_valid = {owner, ~owner};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner  <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            data_q <= '0;
            eq_q   <= 1'b0;
        end else if (state == IDLE && any_req) begin
            owner <= gnt;
            op_q  <= gnt ? bus.req1_op : bus.req0_op;
            a_q   <= gnt ? bus.req1_a  : bus.req0_a;
            b_q   <= gnt ? bus.req1_b  : bus.req0_b;
            c_q   <= gnt ? bus.req1_c  : bus.req0_c;
        end else if (state == EXEC) begin
            data_q <= bus.alu_out;
            eq_q   <= bus.alu_is_equal;
        end
    end

    // ALU sees only registered operands, never the requester buses directly.
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_c     = c_q;
    assign bus.resp_data = data_q;
    assign bus.resp_eq   = eq_q;
endmodule
